stim_reset_stall_gen: RTL and testbench
=======================================

Name: stim_reset_stall_gen

Overview:
Synthesizable stimulus sequencer for CPU-level benches and on-FPGA self-test. After a Start pulse it waits a fixed number of cycles, then asserts DUT reset for a fixed count. It then drives NUM_CH independent stall lines, one for each pipeline or memory port. Each channel runs in one of four modes: off, periodic toggle, pseudo-random, or always.

Parameters:
PRE_RESET_CYCLES, 100, cycles in PRE before DutReset asserts (>=1)
RESET_CYCLES, 30, cycles DutReset is held high (>=1)
NUM_CH, 1, number of independent stall channels (1..8)
PERIOD_W, 8, width of each channel's toggle half-period field
LFSR_SEED, 16'hACE1, base LFSR seed; must be nonzero

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high; clears all state
Start  in  1  one-cycle pulse; honoured only in IDLE
Stop  in  1  returns to IDLE from any state; wins over Start
Mode  in  2*NUM_CH  per channel: 00 off, 01 toggle, 10 random, 11 always
Period  in  PERIOD_W*NUM_CH  per-channel toggle half-period; 0 is treated as 1
Threshold  in  8*NUM_CH  per-channel random stall threshold
DutReset  out  1  reset to the DUT, registered
Stall  out  NUM_CH  stall lines, registered
Running  out  1  high in RUN

Behaviour:
- Reset values: FSM=IDLE, DutReset=0, Stall=0, Running=0, all counters=0. Each LFSR is loaded with LFSR_SEED rotated left by the channel index.
- FSM states: IDLE -> PRE -> HOLD -> RUN -> IDLE.
- IDLE: if Start=1 and Stop=0, go to PRE and load cnt=PRE_RESET_CYCLES-1.
- PRE: DutReset=0. When cnt==0, go to HOLD, load cnt=RESET_CYCLES-1, and set DutReset=1 in the same edge.
- HOLD: when cnt==0, go to RUN, set DutReset=0 and Running=1.
- Timing: if Start is sampled at edge k, DutReset is high from edge k+PRE_RESET_CYCLES through edge k+PRE_RESET_CYCLES+RESET_CYCLES. It falls at that last edge, and Running rises at the same edge.
- Mode, Period and Threshold are latched on the HOLD->RUN edge. Input changes during RUN are ignored until the next run.
- Stall is held 0 outside RUN.
- RUN, per channel:
  - Mode 00: Stall=0.
  - Mode 11: Stall=1.
  - Mode 01: Stall starts at 0 and inverts every max(Period,1) cycles, driven by a per-channel down-counter that reloads on expiry. Example: Period=1 toggles every cycle.
  - Mode 10: the 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) advances every RUN cycle. Stall = (lfsr[7:0] < Threshold), unsigned compare. Threshold=0 never stalls; 255 stalls 255/256 of cycles.
- LFSRs advance only in RUN. They are not reseeded between runs; only Reset reseeds them.
- Stop=1 in any state: next state IDLE, DutReset=0, Stall=0, Running=0. Stop and Start in the same cycle: Stop wins.
- Start outside IDLE is ignored.
- Async Reset mid-run forces all outputs low immediately, without waiting for a clock edge.

Optional Feature:
STIM_RESET_STALL_GEN_STATS_EN
- Defined: adds two output ports:
  - RunCycles (32): counts cycles spent in RUN.
  - StallCycles (32): counts cycles in RUN where Stall[0]=1.
  - Both saturate at 32'hFFFFFFFF, clear on Reset and on IDLE->PRE, and hold their value in IDLE.
- Undefined: neither the ports nor the counters exist.

Test Plan:
- Default parameters, Start pulse at edge 10 -> DutReset high exactly edges 110..140, Running=1 from edge 140, Stall=0 before 140.
- NUM_CH=2, Mode={01,01}, Period={3,1} -> ch0 Stall pattern 000111000…, ch1 pattern 0101… starting at the first RUN cycle.
- Mode=10, Threshold=0 for 1000 cycles -> Stall never 1. Threshold=128 -> Stall count within 500±60. Same seed after Reset reproduces an identical sequence.
- Stop asserted in HOLD -> next cycle IDLE and DutReset=0. Start and Stop in the same cycle in IDLE -> remains IDLE.
- Async Reset pulsed mid-RUN between clock edges -> DutReset, Stall and Running go to 0 before the next edge. A later Start replays the full PRE/HOLD sequence.
- With STIM_RESET_STALL_GEN_STATS_EN, Mode=11 for 50 RUN cycles then Stop -> RunCycles=50, StallCycles=50, both held in IDLE.

Source files
------------

// File: rtl/stim_reset_stall_gen.sv
// Start-triggered DUT reset sequencer driving NUM_CH independent stall channels.
// Define STIM_RESET_STALL_GEN_STATS_EN to add the RunCycles/StallCycles counter ports.
module stim_reset_stall_gen #(
  parameter int unsigned PRE_RESET_CYCLES = 100,
  parameter int unsigned RESET_CYCLES     = 30,
  parameter int unsigned NUM_CH           = 1,
  parameter int unsigned PERIOD_W         = 8,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic                         Stop,
  input  logic [2*NUM_CH-1:0]          Mode,
  input  logic [PERIOD_W*NUM_CH-1:0]   Period,
  input  logic [8*NUM_CH-1:0]          Threshold,
  output logic                         DutReset,
  output logic [NUM_CH-1:0]            Stall,
  output logic                         Running
`ifdef STIM_RESET_STALL_GEN_STATS_EN
  ,
  output logic [31:0]                  RunCycles,
  output logic [31:0]                  StallCycles
`endif
);

  localparam int unsigned CntMax = (PRE_RESET_CYCLES > RESET_CYCLES) ? PRE_RESET_CYCLES
                                                                    : RESET_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] PreLoad   = CntW'(PRE_RESET_CYCLES - 1);
  localparam logic [CntW-1:0] ResetLoad = CntW'(RESET_CYCLES - 1);
  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  typedef enum logic [1:0] {StIdle, StPre, StHold, StRun} stateE;

  function automatic logic [15:0] seedRotl(input int unsigned n);
    logic [31:0] dbl;
    dbl = {LFSR_SEED, LFSR_SEED} << (n % 16);
    return dbl[31:16];
  endfunction

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LfsrTaps) : (v >> 1);
  endfunction

  stateE stateQ, stateD;
  logic [CntW-1:0] cntQ, cntD;
  logic dutResetQ, dutResetD;
  logic runningQ, runningD;
  logic enterRun;

  logic [NUM_CH-1:0]               stallQ, stallD;
  logic [NUM_CH-1:0][1:0]          modeQ, modeD;
  logic [NUM_CH-1:0][PERIOD_W-1:0] periodQ, periodD;
  logic [NUM_CH-1:0][7:0]          thrQ, thrD;
  logic [NUM_CH-1:0][PERIOD_W-1:0] togQ, togD;
  logic [NUM_CH-1:0][15:0]         lfsrQ, lfsrD;

  logic [NUM_CH-1:0][1:0]          effMode;
  logic [NUM_CH-1:0][PERIOD_W-1:0] effPeriod;
  logic [NUM_CH-1:0][PERIOD_W-1:0] reloadVal;
  logic [NUM_CH-1:0][7:0]          effThr;
  logic [NUM_CH-1:0][7:0]          lfsrTap;

  // State register and all sequential state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateQ    <= StIdle;
      cntQ      <= '0;
      dutResetQ <= 1'b0;
      runningQ  <= 1'b0;
      stallQ    <= '0;
      modeQ     <= '0;
      periodQ   <= '0;
      thrQ      <= '0;
      togQ      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        lfsrQ[i] <= seedRotl(i);
      end
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      dutResetQ <= dutResetD;
      runningQ  <= runningD;
      stallQ    <= stallD;
      modeQ     <= modeD;
      periodQ   <= periodD;
      thrQ      <= thrD;
      togQ      <= togD;
      lfsrQ     <= lfsrD;
    end
  end

  // Next-state logic; Stop overrides everything, including a same-cycle Start.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    if (Stop) begin
      stateD = StIdle;
      cntD   = '0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (Start) begin
            stateD = StPre;
            cntD   = PreLoad;
          end
        end
        StPre: begin
          if (cntQ == '0) begin
            stateD = StHold;
            cntD   = ResetLoad;
          end else begin
            cntD = cntQ - CntW'(1);
          end
        end
        StHold: begin
          if (cntQ == '0) begin
            stateD = StRun;
          end else begin
            cntD = cntQ - CntW'(1);
          end
        end
        StRun: begin
          stateD = StRun;
        end
        default: begin
          stateD = StIdle;
        end
      endcase
    end
  end

  // Output logic: the registered outputs follow the next state.
  always_comb begin
    dutResetD = (stateD == StHold);
    runningD  = (stateD == StRun);
    enterRun  = (stateQ == StHold) && (stateD == StRun);
  end

  // Per-channel stall generation; config is taken straight from the inputs on the entry edge.
  always_comb begin
    modeD     = modeQ;
    periodD   = periodQ;
    thrD      = thrQ;
    togD      = togQ;
    lfsrD     = lfsrQ;
    stallD    = '0;
    effMode   = '0;
    effPeriod = '0;
    reloadVal = '0;
    effThr    = '0;
    lfsrTap   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      effMode[i]   = enterRun ? Mode[2*i +: 2] : modeQ[i];
      effPeriod[i] = enterRun ? Period[PERIOD_W*i +: PERIOD_W] : periodQ[i];
      effThr[i]    = enterRun ? Threshold[8*i +: 8] : thrQ[i];
      reloadVal[i] = (effPeriod[i] == '0) ? '0 : effPeriod[i] - PERIOD_W'(1);
      modeD[i]     = effMode[i];
      periodD[i]   = effPeriod[i];
      thrD[i]      = effThr[i];
      if (stateQ == StRun) begin
        lfsrD[i] = lfsrStep(lfsrQ[i]);
      end
      // The first RUN cycle shows the LFSR value held at entry; later cycles the advanced one.
      lfsrTap[i] = enterRun ? lfsrQ[i][7:0] : lfsrD[i][7:0];
      if (runningD) begin
        unique case (effMode[i])
          2'b00: stallD[i] = 1'b0;
          2'b01: begin
            if (enterRun) begin
              stallD[i] = 1'b0;
              togD[i]   = reloadVal[i];
            end else if (togQ[i] == '0) begin
              stallD[i] = ~stallQ[i];
              togD[i]   = reloadVal[i];
            end else begin
              stallD[i] = stallQ[i];
              togD[i]   = togQ[i] - PERIOD_W'(1);
            end
          end
          2'b10: stallD[i] = (lfsrTap[i] < effThr[i]);
          2'b11: stallD[i] = 1'b1;
          default: stallD[i] = 1'b0;
        endcase
      end
    end
  end

  assign DutReset = dutResetQ;
  assign Stall    = stallQ;
  assign Running  = runningQ;

`ifdef STIM_RESET_STALL_GEN_STATS_EN
  logic [31:0] runCntQ, stallCntQ;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      runCntQ   <= '0;
      stallCntQ <= '0;
    end else if ((stateQ == StIdle) && (stateD == StPre)) begin
      runCntQ   <= '0;
      stallCntQ <= '0;
    end else if (stateQ == StRun) begin
      if (runCntQ != '1) begin
        runCntQ <= runCntQ + 32'd1;
      end
      if (stallQ[0] && (stallCntQ != '1)) begin
        stallCntQ <= stallCntQ + 32'd1;
      end
    end
  end

  assign RunCycles   = runCntQ;
  assign StallCycles = stallCntQ;
`endif

endmodule

// File: tb/tb_stim_reset_stall_gen.sv
// Randomized self-checking bench for stim_reset_stall_gen against a cycle-offset reference model.
// Covers the STIM_RESET_STALL_GEN_STATS_EN ports when that macro is defined.
module tb_stim_reset_stall_gen;

  localparam int P   = 100;
  localparam int R   = 30;
  localparam int NCH = 2;
  localparam int PW  = 8;

  logic clk = 1'b0;
  logic rst, start, stop;
  logic [2*NCH-1:0]  mode;
  logic [PW*NCH-1:0] period;
  logic [8*NCH-1:0]  thr;
  logic              dutReset;
  logic [NCH-1:0]    stall;
  logic              running;
`ifdef STIM_RESET_STALL_GEN_STATS_EN
  logic [31:0] runCycles, stallCycles;
`endif

  stim_reset_stall_gen #(
    .PRE_RESET_CYCLES(P),
    .RESET_CYCLES(R),
    .NUM_CH(NCH),
    .PERIOD_W(PW),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .Start(start),
    .Stop(stop),
    .Mode(mode),
    .Period(period),
    .Threshold(thr),
    .DutReset(dutReset),
    .Stall(stall),
    .Running(running)
`ifdef STIM_RESET_STALL_GEN_STATS_EN
    ,
    .RunCycles(runCycles),
    .StallCycles(stallCycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: t counts edges since the accepted Start edge.
  bit          mActive;
  int          mT;
  int          mMode[NCH];
  int          mPer[NCH];
  int          mThr[NCH];
  logic [15:0] mLfsr[NCH];
  longint      mRunCnt, mStallCnt;
  int          edgeNo = 0;

  function automatic logic [15:0] galois(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [15:0] seedFor(input int ch);
    logic [15:0] r;
    r = 16'hACE1;
    for (int k = 0; k < ch; k++) r = {r[14:0], r[15]};
    return r;
  endfunction

  function automatic bit expDut();
    return mActive && (mT >= P) && (mT < P + R);
  endfunction

  function automatic bit expRun();
    return mActive && (mT >= P + R);
  endfunction

  function automatic bit expStall(input int c);
    int n, per;
    if (!expRun()) return 1'b0;
    n   = mT - (P + R);
    per = (mPer[c] == 0) ? 1 : mPer[c];
    case (mMode[c])
      1:       return ((n / per) % 2) == 1;
      2:       return int'(mLfsr[c][7:0]) < mThr[c];
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    mActive   = 1'b0;
    mT        = 0;
    mRunCnt   = 0;
    mStallCnt = 0;
    for (int c = 0; c < NCH; c++) begin
      mLfsr[c] = seedFor(c);
      mMode[c] = 0;
      mPer[c]  = 0;
      mThr[c]  = 0;
    end
  endtask

  task automatic modelEdge();
    bit wasRun, s0;
    wasRun = expRun();
    s0     = expStall(0);
    if (wasRun) begin
      for (int c = 0; c < NCH; c++) mLfsr[c] = galois(mLfsr[c]);
      if (mRunCnt < 64'hFFFFFFFF) mRunCnt++;
      if (s0 && mStallCnt < 64'hFFFFFFFF) mStallCnt++;
    end
    if (stop) begin
      mActive = 1'b0;
    end else if (!mActive) begin
      if (start) begin
        mActive   = 1'b1;
        mT        = 0;
        mRunCnt   = 0;
        mStallCnt = 0;
      end
    end else begin
      mT++;
      if (mT == P + R) begin
        for (int c = 0; c < NCH; c++) begin
          mMode[c] = int'(mode[2*c +: 2]);
          mPer[c]  = int'(period[PW*c +: PW]);
          mThr[c]  = int'(thr[8*c +: 8]);
        end
      end
    end
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) modelReset();
      else begin
        edgeNo++;
        modelEdge();
      end
    end
  end

  // Compare process plus observation recorders for the directed checks.
  bit chkEn = 1'b0;
  bit rec1 = 1'b0, rec2 = 1'b0;
  int firstHigh = -1, lastHigh = -1, firstRun = -1;
  bit q0[$], q1[$];
  int cnt0 = 0, cnt1 = 0, runSeen = 0;

  task automatic compareAll();
    check("dutReset", dutReset, expDut());
    check("running", running, expRun());
    for (int c = 0; c < NCH; c++) check($sformatf("stall[%0d]", c), stall[c], expStall(c));
`ifdef STIM_RESET_STALL_GEN_STATS_EN
    check("runCycles", runCycles, mRunCnt);
    check("stallCycles", stallCycles, mStallCnt);
`endif
    if (rec1) begin
      if (dutReset && firstHigh < 0) firstHigh = edgeNo;
      if (dutReset) lastHigh = edgeNo;
      if (running && firstRun < 0) firstRun = edgeNo;
      if (running && q0.size() < 12) begin
        q0.push_back(stall[0]);
        q1.push_back(stall[1]);
      end
    end
    if (rec2 && running) begin
      runSeen++;
      if (stall[0]) cnt0++;
      if (stall[1]) cnt1++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chkEn) compareAll();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic setCfg(input logic [1:0] m0, input logic [1:0] m1, input logic [7:0] p0,
                        input logic [7:0] p1, input logic [7:0] t0, input logic [7:0] t1);
    mode   = {m1, m0};
    period = {p1, p0};
    thr    = {t1, t0};
  endtask

  int startEdge;
  logic [11:0] pat0, pat1;
  int len;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    mode = '0; period = '0; thr = '0;
    tick(1);
    check("reset dutReset", dutReset, 0);
    check("reset running", running, 0);
    check("reset stall", stall, 0);
    tick(1);
    rst   = 1'b0;
    chkEn = 1'b1;

    // Directed timing with Start sampled at edge 10, both channels toggling.
    setCfg(2'b01, 2'b01, 8'd3, 8'd1, 8'd0, 8'd0);
    while (edgeNo < 9) tick(1);
    startEdge = edgeNo + 1;
    rec1 = 1'b1;
    pulseStart();
    tick(P + R - 1 + 20);
    pulseStop();
    rec1 = 1'b0;
    check("first DutReset edge", firstHigh - startEdge, 100);
    check("last DutReset edge", lastHigh - startEdge, 129);
    check("first Running edge", firstRun - startEdge, 130);
    check("toggle samples", q0.size(), 12);
    pat0 = '0;
    pat1 = '0;
    for (int i = 0; i < 12 && i < q0.size(); i++) begin
      pat0[11-i] = q0[i];
      pat1[11-i] = q1[i];
    end
    check("ch0 period3 pattern", pat0, 12'b000111000111);
    check("ch1 period1 pattern", pat1, 12'b010101010101);

    // Random mode: threshold 0 never stalls, 128 stalls about half the time.
    doReset();
    setCfg(2'b10, 2'b10, 8'd0, 8'd0, 8'd0, 8'd128);
    pulseStart();
    rec2 = 1'b1;
    tick(P + R - 1 + 1000);
    pulseStop();
    rec2 = 1'b0;
    check("random run length", runSeen, 1000);
    check("thr0 stall count", cnt0, 0);
    total++;
    if (cnt1 < 440 || cnt1 > 560) begin
      bad++;
      $display("FAIL thr128 stall count: got %0d want 440..560", cnt1);
    end
    // Reseed after Reset: the model restarts from the seed and checks every cycle.
    doReset();
    setCfg(2'b10, 2'b10, 8'd0, 8'd0, 8'($urandom_range(1, 255)), 8'd128);
    pulseStart();
    tick(P + R - 1 + 200);
    pulseStop();

    // Stop during HOLD, then Start and Stop together in IDLE.
    pulseStart();
    tick(P + 5);
    check("in HOLD before stop", dutReset, 1);
    pulseStop();
    check("stop in HOLD dutReset", dutReset, 0);
    check("stop in HOLD running", running, 0);
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    tick(P + 10);
    check("start+stop stays idle", dutReset, 0);

    // Async Reset between edges mid-RUN.
    setCfg(2'b11, 2'b11, 8'd2, 8'd2, 8'd9, 8'd9);
    pulseStart();
    tick(P + R + 30);
    @(posedge clk);
    #2;
    check("pre-areset running", running, 1);
    rst = 1'b1;
    #1;
    check("areset dutReset", dutReset, 0);
    check("areset running", running, 0);
    check("areset stall", stall, 0);
    tick(1);
    rst = 1'b0;

    // Randomized runs, with inputs scrambled and stray Starts throughout.
    for (int r = 0; r < 5; r++) begin
      setCfg(2'($urandom), 2'($urandom), 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
             8'($urandom), 8'($urandom));
      pulseStart();
      len = (r == 0) ? $urandom_range(1, P + R) : P + R + $urandom_range(5, 80);
      for (int j = 0; j < len; j++) begin
        if (j > P + R - 3) begin
          mode   = 4'($urandom);
          period = 16'($urandom);
          thr    = 16'($urandom);
        end
        start = ($urandom_range(0, 7) == 0);
        tick(1);
      end
      start = 1'b0;
      pulseStop();
      tick(3);
    end

`ifdef STIM_RESET_STALL_GEN_STATS_EN
    setCfg(2'b11, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    pulseStart();
    tick(P + R - 1 + 50);
    pulseStop();
    tick(5);
    check("stats runCycles", runCycles, 50);
    check("stats stallCycles", stallCycles, 50);
`endif

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
